// File: rtl/rtc_bus_ctrl_pkg.sv
// rtl/rtc_bus_ctrl_pkg.sv - shared state encoding and idle bus levels for the RTC bus master
package rtc_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_AGAP = 3'd2,
        ST_DATA = 3'd3,
        ST_DGAP = 3'd4
    } state_e;

    // Levels the RTC pins rest at whenever no phase is driving them
    localparam logic IDLE_CS_N = 1'b1;
    localparam logic IDLE_RD_N = 1'b1;
    localparam logic IDLE_WR_N = 1'b1;
    localparam logic IDLE_A_D  = 1'b1;
    localparam logic IDLE_OE   = 1'b0;

endpackage

// File: rtl/rtc_poll_timer.sv
// rtl/rtc_poll_timer.sv - free-running divider that pulses once every POLL_DIV cycles
module rtc_poll_timer #(
    parameter int POLL_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int CW = $clog2(POLL_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick is the last count value, so the first tick lands POLL_DIV-1 cycles after reset
    assign tick_o = (cnt_q == CW'(POLL_DIV - 1));

    // Count 0..POLL_DIV-1 and wrap
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - transaction engine for the RTC multiplexed address/data bus
module rtc_bus_ctrl
    import rtc_bus_ctrl_pkg::*;
#(
    parameter int          NUM_REGS  = 10,
    parameter logic [7:0]  BASE_ADDR = 8'h21,
    parameter int          PHASE_CYC = 10,
    parameter int          GAP_CYC   = 5,
    parameter int          POLL_DIV  = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [7:0]            wr_addr,
    input  logic [7:0]            wr_data,
    output logic                  wr_ack,
    output logic [8*NUM_REGS-1:0] shadow_flat,
    output logic                  sweep_done,
    output logic                  busy,
    output logic [7:0]            bus_out,
    output logic                  bus_oe,
    input  logic [7:0]            bus_in,
    output logic                  a_d,
    output logic                  cs_n,
    output logic                  rd_n,
    output logic                  wr_n
);

    localparam int MAXC = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [CW-1:0] P_LAST   = CW'(PHASE_CYC - 1);
    localparam logic [CW-1:0] G_LAST   = CW'(GAP_CYC - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REGS - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    is_wr_q, is_wr_d;
    logic [7:0]              addr_q, addr_d;
    logic [7:0]              data_q, data_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic                    pend_q, pend_d;
    logic                    again_q, again_d;
    logic [8*NUM_REGS-1:0]   shadow_q, shadow_d;

    logic                    tick;
    logic                    phase_last;
    logic [7:0]              wr_off;

    rtc_poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    assign phase_last  = ((state_q == ST_ADDR) || (state_q == ST_DATA)) ? (cnt_q == P_LAST)
                                                                         : (cnt_q == G_LAST);
    assign wr_off      = addr_q - BASE_ADDR;
    assign shadow_flat = shadow_q;

    // Next-state, sweep bookkeeping and pin levels for the current phase
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ptr_d      = ptr_q;
        pend_d     = pend_q;
        again_d    = again_q;
        shadow_d   = shadow_q;

        cs_n       = IDLE_CS_N;
        rd_n       = IDLE_RD_N;
        wr_n       = IDLE_WR_N;
        a_d        = IDLE_A_D;
        bus_oe     = IDLE_OE;
        bus_out    = 8'h00;
        wr_ack     = 1'b0;
        sweep_done = 1'b0;
        busy       = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Writes win; a tick in this very cycle may start a sweep without waiting for pend
                if (wr_req) begin
                    is_wr_d = 1'b1;
                    addr_d  = wr_addr;
                    data_d  = wr_data;
                    state_d = ST_ADDR;
                end else if (pend_q || tick) begin
                    is_wr_d = 1'b0;
                    addr_d  = BASE_ADDR + 8'(ptr_q);
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                cs_n    = 1'b0;
                wr_n    = 1'b0;
                a_d     = 1'b0;
                bus_oe  = 1'b1;
                bus_out = addr_q;
                if (phase_last) begin
                    state_d = ST_AGAP;
                    cnt_d   = '0;
                end
            end
            ST_AGAP: begin
                if (phase_last) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                cs_n = 1'b0;
                if (is_wr_q) begin
                    wr_n    = 1'b0;
                    bus_oe  = 1'b1;
                    bus_out = data_q;
                end else begin
                    rd_n = 1'b0;
                end
                if (phase_last) begin
                    state_d = ST_DGAP;
                    cnt_d   = '0;
                    if (!is_wr_q) begin
                        shadow_d[8*int'(ptr_q) +: 8] = bus_in;
                    end
                end
            end
            ST_DGAP: begin
                if (phase_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (is_wr_q) begin
                        wr_ack = 1'b1;
                        // Keep the shadow coherent with writes that land inside the swept window
                        if (wr_off < 8'(NUM_REGS)) begin
                            shadow_d[8*int'(wr_off) +: 8] = data_q;
                        end
                    end else if (ptr_q == PTR_LAST) begin
                        sweep_done = 1'b1;
                        ptr_d      = '0;
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // One sweep may be queued behind the running one; further wraps are dropped
        if (sweep_done) begin
            pend_d  = again_q || tick;
            again_d = 1'b0;
        end else if (tick) begin
            if (pend_q) begin
                again_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            is_wr_q  <= 1'b0;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            ptr_q    <= '0;
            pend_q   <= 1'b0;
            again_q  <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ptr_q    <= ptr_d;
            pend_q   <= pend_d;
            again_q  <= again_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb/tb_rtc_bus_ctrl.sv - directed self-checking bench for rtc_bus_ctrl
module tb_rtc_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        wr_req, wr_ack, sweep_done, busy, bus_oe, a_d, cs_n, rd_n, wr_n;
    logic [7:0]  wr_addr, wr_data, bus_out, bus_in;
    logic [23:0] shadow;

    logic        wr_ack2, sweep_done2, busy2, bus_oe2, a_d2, cs_n2, rd_n2, wr_n2;
    logic [7:0]  bus_out2, bus_in2;
    logic [23:0] shadow2;

    logic [7:0]  maddr = 8'h00;
    logic [7:0]  maddr2 = 8'h00;

    int checks = 0;
    int fails = 0;
    int k = 0;

    int c2 = 0;
    bit rec_stop = 1'b0;
    logic prev2 = 1'b1;
    int done2[$];
    logic [7:0] addr2[$];

    always #5 clk = ~clk;

    rtc_bus_ctrl #(
        .NUM_REGS(3), .BASE_ADDR(8'h21), .PHASE_CYC(4), .GAP_CYC(2), .POLL_DIV(200)
    ) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .shadow_flat(shadow), .sweep_done(sweep_done), .busy(busy),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .a_d(a_d),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n)
    );

    rtc_bus_ctrl #(
        .NUM_REGS(3), .BASE_ADDR(8'h21), .PHASE_CYC(4), .GAP_CYC(2), .POLL_DIV(20)
    ) dut2 (
        .clk(clk), .reset(reset), .wr_req(1'b0), .wr_addr(8'h00), .wr_data(8'h00),
        .wr_ack(wr_ack2), .shadow_flat(shadow2), .sweep_done(sweep_done2), .busy(busy2),
        .bus_out(bus_out2), .bus_oe(bus_oe2), .bus_in(bus_in2), .a_d(a_d2),
        .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2)
    );

    function automatic logic [7:0] rtc_val(input logic [7:0] a);
        case (a)
            8'h21:   rtc_val = 8'h30;
            8'h22:   rtc_val = 8'h45;
            8'h23:   rtc_val = 8'h12;
            default: rtc_val = 8'h00;
        endcase
    endfunction

    // RTC model: latch the address phase, return register contents during reads
    always @(posedge clk) begin
        if (!cs_n && !a_d) maddr <= bus_out;
        if (!cs_n2 && !a_d2) maddr2 <= bus_out2;
    end
    assign bus_in  = rtc_val(maddr);
    assign bus_in2 = rtc_val(maddr2);

    // Cycle index of the fast-poll instance, counted from the reset-release edge
    always @(posedge clk) begin
        if (reset) c2 <= 0;
        else c2 <= c2 + 1;
    end

    // Record sweep_done cycles and address phases of the fast-poll instance up to cycle 400
    always @(negedge clk) begin
        if (!reset && !rec_stop) begin
            if (c2 >= 400) begin
                rec_stop = 1'b1;
            end else begin
                if (sweep_done2) done2.push_back(c2);
                if (a_d2 == 1'b0 && prev2 == 1'b1) addr2.push_back(bus_out2);
                prev2 = a_d2;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    initial begin
        int idle_bad;
        int dn, dk, aw, dw, acks, ack_j, ack_k, bad2;
        logic [7:0] ab, db;
        logic prev;
        logic [7:0] seen[$];

        wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
        idle_bad = 0; dn = 0; dk = 0; aw = 0; dw = 0; acks = 0; ack_j = 0; ack_k = 0; bad2 = 0;
        ab = 8'h00; db = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_shadow", {8'h00, shadow}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_cs_n", {31'b0, cs_n}, 32'h1);
        chk("rst_bus_oe", {31'b0, bus_oe}, 32'h0);
        chk("rst_a_d", {31'b0, a_d}, 32'h1);
        chk("rst_bus_out", {24'b0, bus_out}, 32'h0);
        reset = 1'b0;
        k = 0;

        // No request: bus idle until the first poll wrap
        for (int i = 1; i < 200; i++) begin
            step();
            if (cs_n !== 1'b1 || rd_n !== 1'b1 || wr_n !== 1'b1 || bus_oe !== 1'b0) idle_bad++;
        end
        chk("idle_before_poll", idle_bad, 0);
        step();
        chk("first_addr_bus_out", {24'b0, bus_out}, 32'h21);
        chk("first_addr_strobes", {28'b0, cs_n, wr_n, a_d, bus_oe}, 32'b0001);

        // Sweep: AGAP at 204, DATA (read) at 206
        while (k < 204) step();
        chk("agap_levels", {29'b0, cs_n, a_d, bus_oe}, 32'b110);
        while (k < 206) step();
        chk("read_strobes", {28'b0, cs_n, rd_n, wr_n, bus_oe}, 32'b0010);

        // Reads accepted at 199/212/225 -> sweep_done in cycle 237
        while (k < 260) begin
            step();
            if (sweep_done) begin dn++; dk = k; end
        end
        chk("sweep_done_count", dn, 1);
        chk("sweep_done_cycle", dk, 237);
        chk("sweep_shadow", {8'h00, shadow}, 32'h124530);

        // Single write while idle, accepted in cycle 260
        wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h59;
        for (int j = 1; j <= 16; j++) begin
            step();
            if (a_d == 1'b0 && wr_n == 1'b0 && cs_n == 1'b0) begin
                aw++;
                if (aw == 1) ab = bus_out;
            end
            if (a_d == 1'b1 && wr_n == 1'b0 && cs_n == 1'b0) begin
                dw++;
                if (dw == 1) db = bus_out;
            end
            if (wr_ack) begin acks++; ack_j = j; wr_req = 1'b0; end
        end
        chk("wr_addr_phase_len", aw, 4);
        chk("wr_data_phase_len", dw, 4);
        chk("wr_addr_value", {24'b0, ab}, 32'h22);
        chk("wr_data_value", {24'b0, db}, 32'h59);
        chk("wr_ack_latency", ack_j, 12);
        chk("wr_ack_count", acks, 1);
        chk("wr_coherence", {8'h00, shadow}, 32'h125930);

        // Interleave: write arrives during read 0 of the sweep starting at 399
        while (k < 405) step();
        wr_req = 1'b1; wr_addr = 8'h50; wr_data = 8'hA5;
        prev = a_d;
        dn = 0; dk = 0;
        while (k < 460) begin
            step();
            if (a_d == 1'b0 && prev == 1'b1) seen.push_back(bus_out);
            prev = a_d;
            if (wr_ack) begin ack_k = k; wr_req = 1'b0; end
            if (sweep_done) begin dn++; dk = k; end
        end
        chk("ilv_addr_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("ilv_addr0", {24'b0, seen[0]}, 32'h50);
            chk("ilv_addr1", {24'b0, seen[1]}, 32'h22);
            chk("ilv_addr2", {24'b0, seen[2]}, 32'h23);
        end
        chk("ilv_ack_cycle", ack_k, 424);
        chk("ilv_done_cycle", dk, 450);
        chk("ilv_shadow", {8'h00, shadow}, 32'h124530);

        // Reset during the DATA phase of a write accepted at 470
        while (k < 470) step();
        wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h77;
        while (k < 478) step();
        chk("mid_wr_in_data", {30'b0, a_d, wr_n}, 32'b10);
        reset = 1'b1;
        wr_req = 1'b0;
        step();
        chk("rst_mid_wr_n", {31'b0, wr_n}, 32'h1);
        chk("rst_mid_bus_oe", {31'b0, bus_oe}, 32'h0);
        chk("rst_mid_cs_busy", {30'b0, cs_n, busy}, 32'b10);
        chk("rst_mid_wr_ack", {31'b0, wr_ack}, 32'h0);
        chk("rst_mid_shadow", {8'h00, shadow}, 32'h0);
        chk("rst_mid_bus_out", {24'b0, bus_out}, 32'h0);
        reset = 1'b0;
        acks = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (wr_ack) acks++;
        end
        chk("no_ack_after_reset", acks, 0);

        // Fast-poll instance: sweeps of 39 cycles run back to back from cycle 19
        chk("ovl_done_count", done2.size(), 9);
        if (done2.size() == 9) begin
            chk("ovl_done_first", done2[0], 57);
            chk("ovl_done_last", done2[8], 369);
        end
        chk("ovl_addr_count", addr2.size(), 30);
        foreach (addr2[i]) begin
            if (addr2[i] !== 8'(8'h21 + (i % 3))) bad2++;
        end
        chk("ovl_addr_order", bad2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
